arm_cmd_scheduler: RTL and testbench
====================================

Name: arm_cmd_scheduler

Overview:
Arbitrates pick/drop requests for the shared three-servo arm (claw, high joint, low joint) between two requesters: the navigation FSM and the manual switch path. It sequences the granted operation as a fixed list of setpoint steps. Each step advances only after all three servo FLAGs have been stable for a settle window. It drives the DESIRED inputs of the three Servo instances and reports busy, done and timeout status back to the requesters.

Parameters:
CLAW_CLOSE, 199218, claw closed setpoint (counts at 100 MHz)
CLAW_OPEN, 1, claw open setpoint
UPPER_PICKUP, 31248, high-joint pickup setpoint
UPPER_DROPOFF, 191394, high-joint dropoff/stow setpoint
LOWER_PICKUP, 183400, low-joint pickup setpoint
LOWER_DROPOFF, 113274, low-joint dropoff/stow setpoint
MIN_DWELL, 512, cycles after step entry during which FLAGs are ignored
SETTLE_CYCLES, 5, consecutive cycles all FLAGs must be high to complete a step
STEP_TIMEOUT, 200000000, max cycles per step before abort (2 s)

Ports:
CLK  in  1  system clock, 100 MHz
RST_N  in  1  asynchronous active-low reset
NAV_REQ  in  1  navigation request, level
NAV_OP  in  1  navigation op: 0 = pick, 1 = drop
NAV_ACK  out  1  one-cycle grant pulse to navigation
MAN_REQ  in  1  manual request, level (debounced SW edge)
MAN_OP  in  1  manual op: 0 = pick, 1 = drop
MAN_ACK  out  1  one-cycle grant pulse to manual
CLAW_FLAG  in  1  claw servo at-target
JOINTHIGH_FLAG  in  1  high-joint servo at-target
JOINTLOW_FLAG  in  1  low-joint servo at-target
CLAW_DESIRED  out  20  claw setpoint
JOINTHIGH_DESIRED  out  20  high-joint setpoint
JOINTLOW_DESIRED  out  20  low-joint setpoint
BUSY  out  1  operation in progress
DONE  out  1  one-cycle pulse at operation end (success or abort)
ERROR  out  1  last operation aborted on timeout
GRANT_ID  out  1  owner of current/last grant: 0 = NAV, 1 = MAN

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is CLK, reset port is RST_N.
- Reset values: state IDLE, CLAW_DESIRED = CLAW_OPEN, JOINTHIGH_DESIRED = UPPER_DROPOFF, JOINTLOW_DESIRED = LOWER_DROPOFF. All status outputs and ACKs are 0. Round-robin pointer favours NAV.
- Arbitration, IDLE only:
  - Only one requester high -> grant it.
  - Both high -> grant the one not granted last.
  - Grant edge: ACK pulses 1 cycle, GRANT_ID updates, op latched, BUSY = 1, ERROR cleared, first step entered, setpoints updated.
  - REQ is ignored while BUSY. A REQ still high on return to IDLE is treated as a new request.
- PICK step sequence (claw / high / low):
  - P1 = OPEN / UPPER_PICKUP / LOWER_PICKUP
  - P2 = CLOSE / UPPER_PICKUP / LOWER_PICKUP
  - P3 = CLOSE / UPPER_DROPOFF / LOWER_DROPOFF
- DROP step sequence (claw / high / low):
  - D1 = CLOSE / UPPER_DROPOFF / LOWER_DROPOFF
  - D2 = OPEN / UPPER_DROPOFF / LOWER_DROPOFF
- Step completion:
  - On step entry, the dwell, settle and timeout counters clear.
  - After MIN_DWELL cycles, settle counts up while CLAW_FLAG & JOINTHIGH_FLAG & JOINTLOW_FLAG = 1.
  - Any FLAG low clears settle to 0.
  - When settle reaches SETTLE_CYCLES, advance at the next edge. Setpoints for the new step are registered on that same edge.
- Timeout: the step timer counts every cycle in a step. At STEP_TIMEOUT, abort: ERROR = 1 (sticky until next grant), DONE pulses, go to IDLE. Setpoints hold their last values.
- Completion: on the final step's advance edge, DONE = 1 for 1 cycle, BUSY = 0, state = IDLE. The earliest next grant is the following edge.
- Simultaneous events: if timeout and settle-complete coincide, success wins and ERROR stays 0.
- Reset mid-operation: immediate return to reset values. The in-flight op is discarded and no DONE is issued.
- Counter widths: 28-bit timeout counter, 10-bit dwell counter, 3-bit settle counter. No counter may wrap.
- Setpoint outputs are registered and change only on step entry.

Test Plan:
1. Reset, then NAV_REQ=1, NAV_OP=0, FLAGs tied 1.
   -> NAV_ACK 1 cycle, GRANT_ID=0, CLAW_DESIRED=1, JOINTHIGH=31248, JOINTLOW=183400.
   -> Each step lasts MIN_DWELL+SETTLE_CYCLES+1 = 518 cycles; P2 sets claw 199218, P3 sets high 191394 / low 113274.
   -> DONE pulses at cycle 3*518 after grant, BUSY falls the same edge.
2. NAV_REQ and MAN_REQ both held high from reset, DROP ops.
   -> Grants alternate NAV, MAN, NAV.
   -> Each DONE precedes the next ACK by exactly 1 cycle.
3. Drop op with JOINTLOW_FLAG toggling low every 4th cycle after dwell.
   -> Settle never reaches 5, no advance.
   -> Once the flag is held high, advance exactly 6 cycles later.
4. PICK with CLAW_FLAG stuck 0, STEP_TIMEOUT overridden to 1000.
   -> At cycle 1000 of P1: DONE and ERROR = 1, BUSY = 0, setpoints stay at P1 values.
   -> ERROR clears on the next grant.
5. RST_N asserted mid-P2.
   -> Outputs return to reset values asynchronously, no DONE, IDLE after release.
6. MAN_REQ asserted while BUSY on a NAV op.
   -> No MAN_ACK until NAV's DONE; MAN_ACK the following cycle.

Source files
------------

// File: rtl/arm_cmd_scheduler_if.sv
// Purpose: bundles the requester handshake, servo FLAG inputs and setpoint/status outputs of the arm scheduler.
// Latency: wiring only, no storage.
// Backpressure: none; requesters hold REQ level until ACK, servos report FLAG as a level.
interface arm_cmd_scheduler_if;
    logic        NAV_REQ;
    logic        NAV_OP;
    logic        NAV_ACK;
    logic        MAN_REQ;
    logic        MAN_OP;
    logic        MAN_ACK;
    logic        CLAW_FLAG;
    logic        JOINTHIGH_FLAG;
    logic        JOINTLOW_FLAG;
    logic [19:0] CLAW_DESIRED;
    logic [19:0] JOINTHIGH_DESIRED;
    logic [19:0] JOINTLOW_DESIRED;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;
    logic        GRANT_ID;

    // Requesters and servos drive the request/flag side.
    modport master (
        output NAV_REQ, NAV_OP, MAN_REQ, MAN_OP,
        output CLAW_FLAG, JOINTHIGH_FLAG, JOINTLOW_FLAG,
        input  NAV_ACK, MAN_ACK,
        input  CLAW_DESIRED, JOINTHIGH_DESIRED, JOINTLOW_DESIRED,
        input  BUSY, DONE, ERROR, GRANT_ID
    );

    // The scheduler consumes requests/flags and drives grants, setpoints and status.
    modport slave (
        input  NAV_REQ, NAV_OP, MAN_REQ, MAN_OP,
        input  CLAW_FLAG, JOINTHIGH_FLAG, JOINTLOW_FLAG,
        output NAV_ACK, MAN_ACK,
        output CLAW_DESIRED, JOINTHIGH_DESIRED, JOINTLOW_DESIRED,
        output BUSY, DONE, ERROR, GRANT_ID
    );
endinterface

// File: rtl/arm_cmd_scheduler.sv
// Purpose: round-robin arbiter between NAV and MAN arm requests that sequences pick/drop setpoint steps.
// Latency: grant 1 cycle after REQ in IDLE; each step >= MIN_DWELL+SETTLE_CYCLES+1 cycles; abort after STEP_TIMEOUT.
// Backpressure: REQ is a held level, ignored while BUSY; re-evaluated the cycle after DONE.
module arm_cmd_scheduler #(
    parameter int unsigned CLAW_CLOSE    = 199218,
    parameter int unsigned CLAW_OPEN     = 1,
    parameter int unsigned UPPER_PICKUP  = 31248,
    parameter int unsigned UPPER_DROPOFF = 191394,
    parameter int unsigned LOWER_PICKUP  = 183400,
    parameter int unsigned LOWER_DROPOFF = 113274,
    parameter int unsigned MIN_DWELL     = 512,
    parameter int unsigned SETTLE_CYCLES = 5,
    parameter int unsigned STEP_TIMEOUT  = 200000000
) (
    input  logic                CLK,
    input  logic                RST_N,
    arm_cmd_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1,
        ST_P2,
        ST_P3,
        ST_D1,
        ST_D2
    } state_t;

    typedef struct packed {
        logic [19:0] claw;
        logic [19:0] high;
        logic [19:0] low;
    } sp_t;

    localparam logic [19:0] SP_CLAW_CLOSE = 20'(CLAW_CLOSE);
    localparam logic [19:0] SP_CLAW_OPEN  = 20'(CLAW_OPEN);
    localparam logic [19:0] SP_UP_PICK    = 20'(UPPER_PICKUP);
    localparam logic [19:0] SP_UP_DROP    = 20'(UPPER_DROPOFF);
    localparam logic [19:0] SP_LO_PICK    = 20'(LOWER_PICKUP);
    localparam logic [19:0] SP_LO_DROP    = 20'(LOWER_DROPOFF);

    // Stowed arm with claw open: the power-on pose.
    localparam sp_t SP_STOW = {SP_CLAW_OPEN, SP_UP_DROP, SP_LO_DROP};

    localparam logic [9:0]  DWELL_END    = 10'(MIN_DWELL);
    localparam logic [2:0]  SETTLE_END   = 3'(SETTLE_CYCLES);
    // The timer holds the number of completed cycles in the step, so the
    // abort edge is the one closing cycle STEP_TIMEOUT-1.
    localparam logic [27:0] TIMEOUT_LAST = 28'(STEP_TIMEOUT - 1);

    // Setpoint triple owned by each step.
    function automatic sp_t step_setpoints(input state_t s);
        sp_t sp;
        case (s)
            ST_P1:   sp = {SP_CLAW_OPEN,  SP_UP_PICK, SP_LO_PICK};
            ST_P2:   sp = {SP_CLAW_CLOSE, SP_UP_PICK, SP_LO_PICK};
            ST_P3:   sp = {SP_CLAW_CLOSE, SP_UP_DROP, SP_LO_DROP};
            ST_D1:   sp = {SP_CLAW_CLOSE, SP_UP_DROP, SP_LO_DROP};
            ST_D2:   sp = {SP_CLAW_OPEN,  SP_UP_DROP, SP_LO_DROP};
            default: sp = SP_STOW;
        endcase
        return sp;
    endfunction

    // Fixed step order; the last step of each op returns to IDLE.
    function automatic state_t next_step(input state_t s);
        state_t n;
        case (s)
            ST_P1:   n = ST_P2;
            ST_P2:   n = ST_P3;
            ST_D1:   n = ST_D2;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

    state_t      state_q, state_d;
    sp_t         sp_q, sp_d;
    logic [9:0]  dwell_q, dwell_d;
    logic [2:0]  settle_q, settle_d;
    logic [27:0] timer_q, timer_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        nav_ack_q, nav_ack_d;
    logic        man_ack_q, man_ack_d;
    logic        grant_id_q, grant_id_d;
    // 1 = MAN was granted last; reset to 1 so a tie after reset goes to NAV.
    logic        rr_man_last_q, rr_man_last_d;

    logic        all_flags;
    logic        grant;
    logic        pick_man;
    logic        op;
    state_t      entry_state;

    assign all_flags = bus.CLAW_FLAG & bus.JOINTHIGH_FLAG & bus.JOINTLOW_FLAG;

    assign bus.CLAW_DESIRED      = sp_q.claw;
    assign bus.JOINTHIGH_DESIRED = sp_q.high;
    assign bus.JOINTLOW_DESIRED  = sp_q.low;
    assign bus.BUSY              = busy_q;
    assign bus.DONE              = done_q;
    assign bus.ERROR             = error_q;
    assign bus.NAV_ACK           = nav_ack_q;
    assign bus.MAN_ACK           = man_ack_q;
    assign bus.GRANT_ID          = grant_id_q;

    // Next-state: arbitration in IDLE, dwell/settle/timeout bookkeeping inside a step.
    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        dwell_d       = dwell_q;
        settle_d      = settle_q;
        timer_d       = timer_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = error_q;
        nav_ack_d     = 1'b0;
        man_ack_d     = 1'b0;
        grant_id_d    = grant_id_q;
        rr_man_last_d = rr_man_last_q;
        grant         = 1'b0;
        pick_man      = 1'b0;
        op            = 1'b0;
        entry_state   = ST_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (bus.NAV_REQ && (!bus.MAN_REQ || rr_man_last_q)) begin
                    grant    = 1'b1;
                    pick_man = 1'b0;
                end else if (bus.MAN_REQ) begin
                    grant    = 1'b1;
                    pick_man = 1'b1;
                end

                if (grant) begin
                    op            = pick_man ? bus.MAN_OP : bus.NAV_OP;
                    entry_state   = op ? ST_D1 : ST_P1;
                    state_d       = entry_state;
                    sp_d          = step_setpoints(entry_state);
                    dwell_d       = '0;
                    settle_d      = '0;
                    timer_d       = '0;
                    busy_d        = 1'b1;
                    error_d       = 1'b0;
                    nav_ack_d     = !pick_man;
                    man_ack_d     = pick_man;
                    grant_id_d    = pick_man;
                    rr_man_last_d = pick_man;
                end
            end

            default: begin
                // Settle completion is checked first so it wins over a
                // timeout landing on the same edge.
                if (settle_q == SETTLE_END) begin
                    entry_state = next_step(state_q);
                    state_d     = entry_state;
                    dwell_d     = '0;
                    settle_d    = '0;
                    timer_d     = '0;
                    if (entry_state == ST_IDLE) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        sp_d = step_setpoints(entry_state);
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    // Abort leaves setpoints where they are.
                    state_d  = ST_IDLE;
                    dwell_d  = '0;
                    settle_d = '0;
                    timer_d  = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 28'd1;
                    if (dwell_q != DWELL_END) begin
                        dwell_d = dwell_q + 10'd1;
                    end else if (all_flags) begin
                        settle_d = settle_q + 3'd1;
                    end else begin
                        settle_d = '0;
                    end
                end
            end
        endcase
    end

    // State, counters and registered outputs; reset restores the stowed pose.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            sp_q          <= SP_STOW;
            dwell_q       <= '0;
            settle_q      <= '0;
            timer_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            nav_ack_q     <= 1'b0;
            man_ack_q     <= 1'b0;
            grant_id_q    <= 1'b0;
            rr_man_last_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            dwell_q       <= dwell_d;
            settle_q      <= settle_d;
            timer_q       <= timer_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            nav_ack_q     <= nav_ack_d;
            man_ack_q     <= man_ack_d;
            grant_id_q    <= grant_id_d;
            rr_man_last_q <= rr_man_last_d;
        end
    end

endmodule

// File: tb/tb_arm_cmd_scheduler.sv
// Purpose: scoreboard bench for arm_cmd_scheduler; expected ACK/DONE events and setpoint changes are queued with their cycles.
// Latency: checks exact cycle of every grant, step entry and completion.
// Backpressure: requesters hold REQ levels; the monitor pops one expectation per observed event.
module tb_arm_cmd_scheduler;

    localparam int STEP = 518;
    localparam int TMO  = 1000;

    localparam logic [19:0] C_OPEN  = 20'd1;
    localparam logic [19:0] C_CLOSE = 20'd199218;
    localparam logic [19:0] U_PICK  = 20'd31248;
    localparam logic [19:0] U_DROP  = 20'd191394;
    localparam logic [19:0] L_PICK  = 20'd183400;
    localparam logic [19:0] L_DROP  = 20'd113274;

    localparam logic [59:0] SP_STOW = {C_OPEN,  U_DROP, L_DROP};
    localparam logic [59:0] SP_P1   = {C_OPEN,  U_PICK, L_PICK};
    localparam logic [59:0] SP_P2   = {C_CLOSE, U_PICK, L_PICK};
    localparam logic [59:0] SP_P3   = {C_CLOSE, U_DROP, L_DROP};
    localparam logic [59:0] SP_D1   = {C_CLOSE, U_DROP, L_DROP};
    localparam logic [59:0] SP_D2   = {C_OPEN,  U_DROP, L_DROP};

    localparam int K_NAV  = 0;
    localparam int K_MAN  = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int   kind;
        int   cyc;
        logic gid;
        logic err;
    } ev_t;

    typedef struct {
        logic [59:0] v;
        int          cyc;
    } spx_t;

    ev_t         ev_q[$];
    spx_t        sp_q[$];
    logic [59:0] model_sp;
    logic [59:0] prev_sp;
    logic [59:0] cur_sp;
    ev_t         mev;
    spx_t        msp;
    int          mkind;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    arm_cmd_scheduler_if ifc ();

    arm_cmd_scheduler #(
        .STEP_TIMEOUT (TMO)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (ifc)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic push_ev(input int kind, input int c, input logic gid, input logic err);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.gid  = gid;
        e.err  = err;
        ev_q.push_back(e);
    endtask

    // Only a real change of the outputs is an observable event.
    task automatic exp_sp(input logic [59:0] v, input int c);
        spx_t s;
        if (v !== model_sp) begin
            s.v   = v;
            s.cyc = c;
            sp_q.push_back(s);
            model_sp = v;
        end
    endtask

    // Expected events for an operation granted at edge g with all FLAGs high.
    task automatic expect_op(input logic gid, input logic op, input int g, output int done_c);
        push_ev(gid ? K_MAN : K_NAV, g, gid, 1'b0);
        if (!op) begin
            exp_sp(SP_P1, g);
            exp_sp(SP_P2, g + STEP);
            exp_sp(SP_P3, g + 2 * STEP);
            done_c = g + 3 * STEP;
        end else begin
            exp_sp(SP_D1, g);
            exp_sp(SP_D2, g + STEP);
            done_c = g + 2 * STEP;
        end
        push_ev(K_DONE, done_c, gid, 1'b0);
    endtask

    // Monitor: pops one expectation per ACK/DONE pulse and per setpoint change.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (ifc.NAV_ACK || ifc.MAN_ACK || ifc.DONE) begin
                mkind = ifc.DONE ? K_DONE : (ifc.MAN_ACK ? K_MAN : K_NAV);
                if (ev_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", mkind, cyc);
                end else begin
                    mev = ev_q.pop_front();
                    chk("event_kind", mkind, mev.kind);
                    chk("event_cycle", cyc, mev.cyc);
                    chk("grant_id", ifc.GRANT_ID, mev.gid);
                    chk("error_flag", ifc.ERROR, mev.err);
                    chk("busy_flag", ifc.BUSY, (mev.kind == K_DONE) ? 0 : 1);
                end
            end
            cur_sp = {ifc.CLAW_DESIRED, ifc.JOINTHIGH_DESIRED, ifc.JOINTLOW_DESIRED};
            if (cur_sp !== prev_sp) begin
                if (sp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_setpoint: got %0d/%0d/%0d at cycle %0d expected no change",
                             cur_sp[59:40], cur_sp[39:20], cur_sp[19:0], cyc);
                end else begin
                    msp = sp_q.pop_front();
                    chk("sp_claw", cur_sp[59:40], msp.v[59:40]);
                    chk("sp_high", cur_sp[39:20], msp.v[39:20]);
                    chk("sp_low", cur_sp[19:0], msp.v[19:0]);
                    chk("sp_cycle", cyc, msp.cyc);
                end
                prev_sp = cur_sp;
            end
        end
    end

    initial begin
        int g;
        int g2;
        int g3;
        int d;
        int d2;
        int d3;

        ifc.NAV_REQ        = 1'b0;
        ifc.NAV_OP         = 1'b0;
        ifc.MAN_REQ        = 1'b0;
        ifc.MAN_OP         = 1'b0;
        ifc.CLAW_FLAG      = 1'b1;
        ifc.JOINTHIGH_FLAG = 1'b1;
        ifc.JOINTLOW_FLAG  = 1'b1;
        model_sp           = SP_STOW;
        prev_sp            = SP_STOW;

        // Reset values.
        tick(3);
        chk("rst_claw", ifc.CLAW_DESIRED, C_OPEN);
        chk("rst_high", ifc.JOINTHIGH_DESIRED, U_DROP);
        chk("rst_low", ifc.JOINTLOW_DESIRED, L_DROP);
        chk("rst_busy", ifc.BUSY, 0);
        chk("rst_done", ifc.DONE, 0);
        chk("rst_error", ifc.ERROR, 0);
        chk("rst_nav_ack", ifc.NAV_ACK, 0);
        chk("rst_man_ack", ifc.MAN_ACK, 0);
        chk("rst_grant_id", ifc.GRANT_ID, 0);
        RST_N  = 1'b1;
        mon_en = 1'b1;
        tick(2);

        // 1: NAV pick, FLAGs high: three 518-cycle steps.
        g = cyc + 1;
        expect_op(1'b0, 1'b0, g, d);
        ifc.NAV_REQ = 1'b1;
        ifc.NAV_OP  = 1'b0;
        tick(1);
        ifc.NAV_REQ = 1'b0;
        tick_to(d + 2);

        // 2: both requesters held from reset, drops: NAV, MAN, NAV back to back.
        exp_sp(SP_STOW, cyc);
        RST_N = 1'b0;
        tick(3);
        ifc.NAV_REQ = 1'b1;
        ifc.MAN_REQ = 1'b1;
        ifc.NAV_OP  = 1'b1;
        ifc.MAN_OP  = 1'b1;
        g = cyc + 1;
        expect_op(1'b0, 1'b1, g, d);
        g2 = d + 1;
        expect_op(1'b1, 1'b1, g2, d2);
        g3 = d2 + 1;
        expect_op(1'b0, 1'b1, g3, d3);
        RST_N = 1'b1;
        tick_to(g3);
        ifc.NAV_REQ = 1'b0;
        ifc.MAN_REQ = 1'b0;
        tick_to(d3 + 2);

        // 3: drop with JOINTLOW_FLAG low every 4th cycle; advance 6 cycles after it holds high.
        g = cyc + 1;
        push_ev(K_NAV, g, 1'b0, 1'b0);
        exp_sp(SP_D1, g);
        exp_sp(SP_D2, g + 606);
        push_ev(K_DONE, g + 606 + STEP, 1'b0, 1'b0);
        ifc.NAV_REQ = 1'b1;
        ifc.NAV_OP  = 1'b1;
        tick(1);
        ifc.NAV_REQ = 1'b0;
        for (int j = 0; j < 600; j++) begin
            ifc.JOINTLOW_FLAG = ((j % 4) != 3);
            tick(1);
        end
        ifc.JOINTLOW_FLAG = 1'b1;
        tick_to(g + 606 + STEP + 2);

        // 4: MAN pick with CLAW_FLAG stuck low: abort after 1000 cycles of P1.
        g = cyc + 1;
        push_ev(K_MAN, g, 1'b1, 1'b0);
        exp_sp(SP_P1, g);
        push_ev(K_DONE, g + TMO, 1'b1, 1'b1);
        ifc.MAN_REQ   = 1'b1;
        ifc.MAN_OP    = 1'b0;
        ifc.CLAW_FLAG = 1'b0;
        tick(1);
        ifc.MAN_REQ = 1'b0;
        tick_to(g + TMO + 3);
        chk("abort_error_sticky", ifc.ERROR, 1);
        chk("abort_busy", ifc.BUSY, 0);
        chk("abort_hold_claw", ifc.CLAW_DESIRED, C_OPEN);
        chk("abort_hold_high", ifc.JOINTHIGH_DESIRED, U_PICK);
        chk("abort_hold_low", ifc.JOINTLOW_DESIRED, L_PICK);
        ifc.CLAW_FLAG = 1'b1;

        // 5: reset mid-P2; ERROR must already clear on this grant.
        g = cyc + 1;
        push_ev(K_NAV, g, 1'b0, 1'b0);
        exp_sp(SP_P1, g);
        exp_sp(SP_P2, g + STEP);
        ifc.NAV_REQ = 1'b1;
        ifc.NAV_OP  = 1'b0;
        tick(1);
        ifc.NAV_REQ = 1'b0;
        tick_to(g + STEP + 100);
        exp_sp(SP_STOW, cyc);
        RST_N = 1'b0;
        #1;
        chk("async_rst_claw", ifc.CLAW_DESIRED, C_OPEN);
        chk("async_rst_high", ifc.JOINTHIGH_DESIRED, U_DROP);
        chk("async_rst_busy", ifc.BUSY, 0);
        tick(2);
        RST_N = 1'b1;
        tick(20);
        chk("post_rst_busy", ifc.BUSY, 0);
        chk("post_rst_error", ifc.ERROR, 0);
        chk("post_rst_grant_id", ifc.GRANT_ID, 0);

        // 6: MAN raised while NAV busy: MAN_ACK the cycle after NAV's DONE.
        g = cyc + 1;
        expect_op(1'b0, 1'b0, g, d);
        g2 = d + 1;
        expect_op(1'b1, 1'b1, g2, d2);
        ifc.NAV_REQ = 1'b1;
        ifc.NAV_OP  = 1'b0;
        tick(1);
        ifc.NAV_REQ = 1'b0;
        tick(10);
        ifc.MAN_REQ = 1'b1;
        ifc.MAN_OP  = 1'b1;
        tick_to(g2);
        ifc.MAN_REQ = 1'b0;
        tick_to(d2 + 3);

        chk("events_outstanding", ev_q.size(), 0);
        chk("setpoints_outstanding", sp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
